huffman_enc_sequencer: RTL

HUFFMAN_ENC_SEQUENCER -- requirements
Module: huffman_enc_sequencer

---
 rtl/huffman_pkg.sv | 27 ++
 rtl/huffman_enc_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman encoder front-end sequencer.
//   state_e        : sequencer FSM states
//   SYM_W          : symbol width in bits
//   BYTES_PER_WORD : symbols packed per input word (byte 0 first)
//   get_byte()     : selects one symbol lane out of a packed word
package huffman_pkg;

    localparam int unsigned SYM_W          = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = SYM_W * BYTES_PER_WORD;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StFlush,
        StWaitFlush,
        StDone
    } state_e;

    function automatic logic [SYM_W-1:0] get_byte(input logic [WORD_W-1:0] word,
                                                  input logic [IDX_W-1:0]  idx);
        return word[32'(idx) * SYM_W +: SYM_W];
    endfunction

endpackage

// File: rtl/huffman_enc_sequencer.sv
// Huffman encoder job sequencer.
// Unpacks 32-bit symbol words into a byte stream for the encoder core, counts
// symbols against a programmed job length, then flushes the core and raises
// done/irq. Supports abort and a bounded wait for the core flush acknowledge.
//
// Ports
//   ACLK, ARESETN         : clock, asynchronous active-low reset
//   cfg_start, cfg_abort  : single-cycle job control
//   cfg_sym_count         : job length in symbols, sampled on an accepted start
//   in_wdata/wvalid/wready: packed word input (byte 0 = bits [7:0], sent first)
//   sym_data/valid/ready  : symbol stream to the core, sym_last on final symbol
//   core_flush            : one-cycle flush request to the core
//   core_flush_done       : core flush acknowledge
//   core_clear            : one-cycle core state clear (abort / timeout)
//   busy, done, aborted, err_timeout, irq, sym_processed : status
module huffman_enc_sequencer
    import huffman_pkg::*;
#(
    parameter int unsigned COUNT_W       = 16,
    parameter int unsigned FLUSH_TIMEOUT = 1024
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [COUNT_W-1:0] cfg_sym_count,
    input  logic [31:0]        in_wdata,
    input  logic               in_wvalid,
    output logic               in_wready,
    output logic [7:0]         sym_data,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic               sym_last,
    output logic               core_flush,
    input  logic               core_flush_done,
    output logic               core_clear,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               err_timeout,
    output logic               irq,
    output logic [COUNT_W-1:0] sym_processed
);

    localparam int unsigned          TIMER_W = $clog2(FLUSH_TIMEOUT) + 1;
    localparam logic [COUNT_W:0]     ONE_EXT = 1;
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(FLUSH_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

    state_e              r_state;
    logic [COUNT_W-1:0]  r_count;
    logic [WORD_W-1:0]   r_word;
    logic [IDX_W-1:0]    r_idx;
    logic [TIMER_W-1:0]  r_timer;
    logic [COUNT_W-1:0]  r_sym_processed;

    logic                r_in_wready;
    logic [SYM_W-1:0]    r_sym_data;
    logic                r_sym_valid;
    logic                r_sym_last;
    logic                r_core_flush;
    logic                r_core_clear;
    logic                r_busy;
    logic                r_done;
    logic                r_aborted;
    logic                r_err_timeout;
    logic                r_irq;

    // One extra bit so the count comparisons cannot overflow at full scale.
    logic [COUNT_W:0]    w_cnt_ext;
    logic [COUNT_W:0]    w_proc_p1;
    logic [COUNT_W:0]    w_proc_p2;
    logic [IDX_W-1:0]    w_idx_nxt;

    assign w_cnt_ext = {1'b0, r_count};
    assign w_proc_p1 = {1'b0, r_sym_processed} + ONE_EXT;
    assign w_proc_p2 = w_proc_p1 + ONE_EXT;
    assign w_idx_nxt = r_idx + IDX_W'(1);

    // Outputs are registered; each transition loads the values the next state
    // presents, so no output depends combinationally on an input.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state         <= StIdle;
            r_count         <= '0;
            r_word          <= '0;
            r_idx           <= '0;
            r_timer         <= '0;
            r_sym_processed <= '0;
            r_in_wready     <= 1'b0;
            r_sym_data      <= '0;
            r_sym_valid     <= 1'b0;
            r_sym_last      <= 1'b0;
            r_core_flush    <= 1'b0;
            r_core_clear    <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_aborted       <= 1'b0;
            r_err_timeout   <= 1'b0;
            r_irq           <= 1'b0;
        end else begin
            r_core_flush <= 1'b0;
            r_core_clear <= 1'b0;
            r_irq        <= 1'b0;

            // Abort wins over everything once a job is running, including a
            // coincident start.
            if (cfg_abort && (r_state != StIdle)) begin
                r_state      <= StIdle;
                r_core_clear <= 1'b1;
                r_aborted    <= 1'b1;
                r_sym_valid  <= 1'b0;
                r_sym_last   <= 1'b0;
                r_in_wready  <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (cfg_start) begin
                            r_count         <= cfg_sym_count;
                            r_done          <= 1'b0;
                            r_aborted       <= 1'b0;
                            r_err_timeout   <= 1'b0;
                            r_sym_processed <= '0;
                            r_busy          <= 1'b1;
                            if (cfg_sym_count != '0) begin
                                r_state     <= StFetch;
                                r_in_wready <= 1'b1;
                            end else begin
                                r_state      <= StFlush;
                                r_core_flush <= 1'b1;
                            end
                        end
                    end

                    StFetch: begin
                        if (in_wvalid) begin
                            r_word      <= in_wdata;
                            r_idx       <= '0;
                            r_in_wready <= 1'b0;
                            r_sym_valid <= 1'b1;
                            r_sym_data  <= get_byte(in_wdata, '0);
                            r_sym_last  <= (w_proc_p1 == w_cnt_ext);
                            r_state     <= StIssue;
                        end
                    end

                    StIssue: begin
                        if (sym_ready) begin
                            if (w_proc_p1 <= w_cnt_ext) begin
                                r_sym_processed <= w_proc_p1[COUNT_W-1:0];
                            end
                            r_idx <= w_idx_nxt;
                            if (w_proc_p1 >= w_cnt_ext) begin
                                // Job complete; any bytes left in the word are dropped.
                                r_sym_valid  <= 1'b0;
                                r_sym_last   <= 1'b0;
                                r_core_flush <= 1'b1;
                                r_state      <= StFlush;
                            end else if (r_idx == IDX_LAST) begin
                                r_sym_valid <= 1'b0;
                                r_sym_last  <= 1'b0;
                                r_in_wready <= 1'b1;
                                r_state     <= StFetch;
                            end else begin
                                r_sym_data <= get_byte(r_word, w_idx_nxt);
                                r_sym_last <= (w_proc_p2 == w_cnt_ext);
                            end
                        end
                    end

                    StFlush: begin
                        r_timer <= '0;
                        r_state <= StWaitFlush;
                    end

                    StWaitFlush: begin
                        if (core_flush_done) begin
                            r_done  <= 1'b1;
                            r_irq   <= 1'b1;
                            r_state <= StDone;
                        end else if (r_timer == TIMER_LAST) begin
                            r_err_timeout <= 1'b1;
                            r_core_clear  <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= StIdle;
                        end else begin
                            r_timer <= r_timer + TIMER_W'(1);
                        end
                    end

                    StDone: begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end

                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign in_wready     = r_in_wready;
    assign sym_data      = r_sym_data;
    assign sym_valid     = r_sym_valid;
    assign sym_last      = r_sym_last;
    assign core_flush    = r_core_flush;
    assign core_clear    = r_core_clear;
    assign busy          = r_busy;
    assign done          = r_done;
    assign aborted       = r_aborted;
    assign err_timeout   = r_err_timeout;
    assign irq           = r_irq;
    assign sym_processed = r_sym_processed;

endmodule
